// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory-port arbiter.
package mem_arb_pkg;

    // Arbiter state: idle, or busy on behalf of fetch or data.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2
    } arb_state_e;

    // Which requester owns the in-flight access.
    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } arb_owner_e;

    // RISC-V canonical NOP (addi x0, x0, 0), returned on an aborted fetch.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Busy state that corresponds to a given owner.
    function automatic arb_state_e owner_state(arb_owner_e own);
        return (own == OWN_D) ? BUSY_D : BUSY_IF;
    endfunction

endpackage

// File: rtl/arb_timeout_cnt.sv
// Access-timeout counter: counts cycles spent waiting for mem_ack and flags
// the cycle in which the wait reaches TIMEOUT_CYC. Only used with MEM_TIMEOUT_EN.
module arb_timeout_cnt #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expire
);
    localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q;

    // Terminal count: this waiting cycle is the TIMEOUT_CYC-th one.
    assign expire = inc && (cnt_q == LAST);

    // Count waiting cycles; restart on every grant and after expiry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc) begin
            cnt_q <= expire ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and
// load/store. Data wins over fetch; one access in flight; stall while busy.
// Optional build macro MEM_TIMEOUT_EN adds an access timeout with sticky err.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                stall,
    output logic                err
);
    localparam int unsigned BE_W = DATA_W / 8;

    arb_state_e state_q, state_d;
    arb_owner_e gnt_own, cur_own;
    logic       grant;
    logic       done;
    logic       abort;

    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [BE_W-1:0]   mem_be_q;
    logic              if_rvalid_q, d_rvalid_q;
    logic [DATA_W-1:0] if_rdata_q, d_rdata_q;

    assign cur_own = (state_q == BUSY_D) ? OWN_D : OWN_IF;

    // Next state and grants; grants are suppressed while reset is asserted.
    always_comb begin
        state_d = state_q;
        if_gnt  = 1'b0;
        d_gnt   = 1'b0;
        grant   = 1'b0;
        gnt_own = OWN_IF;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!rst && d_req) begin
                    d_gnt   = 1'b1;
                    grant   = 1'b1;
                    gnt_own = OWN_D;
                    state_d = owner_state(OWN_D);
                end else if (!rst && if_req) begin
                    if_gnt  = 1'b1;
                    grant   = 1'b1;
                    gnt_own = OWN_IF;
                    state_d = owner_state(OWN_IF);
                end
            end
            BUSY_IF, BUSY_D: begin
                if (mem_ack || abort) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Memory request: latch the winner's attributes on grant, hold until done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
        end else if (grant) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= (gnt_own == OWN_D) ? d_we : 1'b0;
            mem_addr_q  <= (gnt_own == OWN_D) ? d_addr : if_addr;
            mem_wdata_q <= (gnt_own == OWN_D) ? d_wdata : '0;
            mem_be_q    <= (gnt_own == OWN_D) ? d_be : '1;
        end else if (done) begin
            mem_req_q   <= 1'b0;
        end
    end

    // Completion pulses and read data; rdata holds between pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            if_rvalid_q <= done && (cur_own == OWN_IF);
            d_rvalid_q  <= done && (cur_own == OWN_D);
            if (done && (cur_own == OWN_IF)) begin
                if_rdata_q <= abort ? DATA_W'(NOP_INSTR) : mem_rdata;
            end
            if (done && (cur_own == OWN_D)) begin
                d_rdata_q <= abort ? '0 : mem_rdata;
            end
        end
    end

`ifdef MEM_TIMEOUT_EN
    logic expire;
    logic err_q;

    arb_timeout_cnt #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .clk   (clk),
        .rst   (rst),
        .clr   (grant),
        .inc   (mem_req_q && !mem_ack),
        .expire(expire)
    );

    // An ack in the terminal cycle wins because expire requires !mem_ack.
    assign abort = expire;

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (abort) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYC;
    assign abort          = 1'b0;
    assign err            = 1'b0;
`endif

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;
    assign if_rvalid = if_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign d_rvalid  = d_rvalid_q;
    assign d_rdata   = d_rdata_q;
    assign stall     = (state_q != IDLE);

endmodule
